// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int CLKDIV_CNT_W_DEF = 8;
  localparam int CLKDIV_DEF_HALF  = 2;

  typedef logic [CLKDIV_CNT_W_DEF-1:0] clkdiv_cnt_t;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: half-period counter, toggling output and a single-entry
// pending-load register applied at the next toggle boundary.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int CNT_W    = CLKDIV_CNT_W_DEF,
  parameter int DEF_HALF = CLKDIV_DEF_HALF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_gate,
  input  logic             i_load_valid,
  input  logic [CNT_W-1:0] i_load_data,
  output logic             o_load_ready,
  output logic             o_div_clk,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pend_val;
  logic             r_pend;
  logic             r_div;
  logic             r_tick;

  logic w_accept;
  logic w_wrap;

  assign w_accept = i_load_valid && !r_pend;
  assign w_wrap   = !(r_cnt < r_half);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_half     <= CNT_W'(DEF_HALF);
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_div      <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      // sync and gate share the same effect, so one branch covers both.
      if (i_sync || i_gate) begin
        r_cnt <= '0;
        r_div <= 1'b0;
        if (r_pend) begin
          r_half <= r_pend_val;
          r_pend <= 1'b0;
        end
      end else if (i_en) begin
        if (w_wrap) begin
          r_cnt  <= '0;
          r_div  <= ~r_div;
          r_tick <= 1'b1;
          if (r_pend) begin
            r_half <= r_pend_val;
            r_pend <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      // NOTE: non-blocking assignments read the pre-edge r_pend above, so a
      // load accepted this cycle cannot be applied by a wrap or sync in the
      // same cycle; acceptance requires r_pend == 0, so there is no clash.
      if (w_accept) begin
        r_pend     <= 1'b1;
        r_pend_val <= i_load_data;
      end
    end
  end

  assign o_load_ready = ~r_pend;
  assign o_div_clk    = r_div;
  assign o_tick       = r_tick;

endmodule

// File: rtl/clkdiv_multi.sv
// NCH-channel clock divider with programmable half-periods, shared enable and sync.
// Define CLKDIV_GATE_EN to add the per-channel gate input.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int CNT_W    = CLKDIV_CNT_W_DEF,
  parameter int DEF_HALF = CLKDIV_DEF_HALF
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 en,
  input  logic                 sync,
`ifdef CLKDIV_GATE_EN
  input  logic [NCH-1:0]       gate,
`endif
  input  logic [NCH-1:0]       load_valid,
  input  logic [NCH*CNT_W-1:0] load_data,
  output logic [NCH-1:0]       load_ready,
  output logic [NCH-1:0]       div_clk,
  output logic [NCH-1:0]       tick
);

  logic [NCH-1:0] w_gate;

`ifdef CLKDIV_GATE_EN
  assign w_gate = gate;
`else
  assign w_gate = '0;
`endif

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    clkdiv_chan #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .clk          (clk),
      .n_rst        (n_rst),
      .i_en         (en),
      .i_sync       (sync),
      .i_gate       (w_gate[gi]),
      .i_load_valid (load_valid[gi]),
      .i_load_data  (load_data[gi*CNT_W +: CNT_W]),
      .o_load_ready (load_ready[gi]),
      .o_div_clk    (div_clk[gi]),
      .o_tick       (tick[gi])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed self-checking bench for clkdiv_multi (NCH=2, CNT_W=8, DEF_HALF=2).
// Gate checks are included when CLKDIV_GATE_EN is defined.
module tb_clkdiv_multi;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        en;
  logic        sync;
  logic [1:0]  load_valid;
  logic [15:0] load_data;
  logic [1:0]  load_ready;
  logic [1:0]  div_clk;
  logic [1:0]  tick;
`ifdef CLKDIV_GATE_EN
  logic [1:0]  gate;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  clkdiv_multi #(.NCH(2), .CNT_W(8), .DEF_HALF(2)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .en         (en),
    .sync       (sync),
`ifdef CLKDIV_GATE_EN
    .gate       (gate),
`endif
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .div_clk    (div_clk),
    .tick       (tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (edge %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    n_rst = 1'b0; en = 1'b0; sync = 1'b0; load_valid = '0; load_data = '0;
`ifdef CLKDIV_GATE_EN
    gate = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_div", div_clk, 2'b00);
    check("rst_tick", tick, 2'b00);
    check("rst_ready", load_ready, 2'b11);

    // Defaults: divide-by-6, rise after edge 3, tick every 3 edges.
    n_rst = 1'b1; en = 1'b1; cyc = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("dflt_div", div_clk, ((k % 6) >= 3) ? 2'b11 : 2'b00);
      check("dflt_tick", tick, ((k % 3) == 0) ? 2'b11 : 2'b00);
    end

    // Channel 1 loads half=0 mid-period; applied at wrap on edge 15.
    step();                                    // 13
    load_valid = 2'b10; load_data = 16'h0000;
    step();                                    // 14
    check("ld0_ready", load_ready, 2'b01);
    check("ld0_div14", div_clk, 2'b00);
    check("ld0_tick14", tick, 2'b00);
    load_valid = 2'b00;
    step();                                    // 15
    check("ld0_ready15", load_ready, 2'b11);
    check("ld0_div15", div_clk, 2'b11);
    check("ld0_tick15", tick, 2'b11);
    step();                                    // 16
    check("ld0_div16", div_clk, 2'b01);
    check("ld0_tick16", tick, 2'b10);
    step();                                    // 17
    check("ld0_div17", div_clk, 2'b11);
    check("ld0_tick17", tick, 2'b10);
    step();                                    // 18
    check("ld0_div18", div_clk, 2'b00);
    check("ld0_tick18", tick, 2'b11);

    // Channel 0 load accepted on its wrap edge 21; second request ignored.
    step(); step();                            // 19, 20
    load_valid = 2'b01; load_data = 16'h0004;
    step();                                    // 21
    check("wl_tick21", tick, 2'b11);
    check("wl_div21", div_clk, 2'b11);
    check("wl_ready21", load_ready, 2'b10);
    load_data = 16'h0007;
    step();                                    // 22
    check("wl_ready22", load_ready, 2'b10);
    step();                                    // 23
    load_valid = 2'b00;
    step();                                    // 24
    check("wl_tick24", tick, 2'b11);
    check("wl_ready24", load_ready, 2'b11);
    check("wl_div24", div_clk, 2'b00);
    for (int k = 25; k <= 34; k++) begin
      step();
      check("wl_tick0", tick[0], (cyc == 29) || (cyc == 34));
    end
    check("wl_div34", div_clk, 2'b00);

    // Enable low for 5 edges with channel 0 at cnt=2.
    step(); step();                            // 35, 36
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_tick", tick, 2'b00);
      check("hold_div", div_clk, 2'b00);
    end
    en = 1'b1;
    step();                                    // 42
    check("res_div42", div_clk, 2'b10);
    check("res_tick42", tick, 2'b10);
    step();                                    // 43
    check("res_div43", div_clk, 2'b00);
    check("res_tick43", tick, 2'b10);
    step();                                    // 44
    check("res_div44", div_clk, 2'b11);
    check("res_tick44", tick, 2'b11);

    // Load half=1 / half=3, then sync applies both and aligns phase.
    load_valid = 2'b11; load_data = {8'd3, 8'd1};
    step();                                    // 45
    load_valid = 2'b00; sync = 1'b1;
    step();                                    // 46
    check("sync_div", div_clk, 2'b00);
    check("sync_tick", tick, 2'b00);
    check("sync_ready", load_ready, 2'b11);
    sync = 1'b0;
    step();                                    // 47
    check("al_tick47", tick, 2'b00);
    step();                                    // 48
    check("al_div48", div_clk, 2'b01);
    check("al_tick48", tick, 2'b01);
    step();                                    // 49
    check("al_tick49", tick, 2'b00);
    step();                                    // 50
    check("al_div50", div_clk, 2'b10);
    check("al_tick50", tick, 2'b11);
    step();                                    // 51
    step();                                    // 52
    check("al_div52", div_clk, 2'b11);
    check("al_tick52", tick, 2'b01);
    step();                                    // 53
    check("al_div53", div_clk, 2'b11);

    // Sync with enable low still clears and aligns.
    en = 1'b0; sync = 1'b1;
    step();                                    // 54
    check("syn0_div", div_clk, 2'b00);
    check("syn0_tick", tick, 2'b00);
    sync = 1'b0; en = 1'b1;
    step();                                    // 55
    step();                                    // 56
    check("syn0_div56", div_clk, 2'b01);
    check("syn0_tick56", tick, 2'b01);
    step();                                    // 57
    step();                                    // 58
    check("syn0_div58", div_clk, 2'b10);
    check("syn0_tick58", tick, 2'b11);

    // Load accepted together with sync stays pending past that sync.
    load_valid = 2'b01; load_data = 16'h0005; sync = 1'b1;
    step();                                    // 59
    check("sl_ready59", load_ready, 2'b10);
    check("sl_div59", div_clk, 2'b00);
    load_valid = 2'b00; sync = 1'b0;
    step();                                    // 60
    check("sl_tick60", tick[0], 1'b0);
    check("sl_ready60", load_ready, 2'b10);
    step();                                    // 61
    check("sl_tick61", tick[0], 1'b1);
    check("sl_ready61", load_ready, 2'b11);
    for (int k = 62; k <= 67; k++) begin
      step();
      check("sl_tick0", tick[0], cyc == 67);
    end
    for (int k = 68; k <= 73; k++) step();
    check("sl_div73", div_clk[0], 1'b1);
    check("sl_tick73", tick[0], 1'b1);

    // Asynchronous reset mid-period with cnt=1, div_clk=1, pend set.
    load_valid = 2'b01; load_data = 16'h0009;
    step();                                    // 74
    check("pre_rst_ready", load_ready, 2'b10);
    check("pre_rst_div", div_clk[0], 1'b1);
    load_valid = 2'b00;
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_div", div_clk, 2'b00);
    check("arst_tick", tick, 2'b00);
    check("arst_ready", load_ready, 2'b11);
    @(posedge clk);
    #1;
    n_rst = 1'b1; cyc = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("post_rst_div", div_clk, (k == 3) ? 2'b11 : 2'b00);
      check("post_rst_tick", tick, (k == 3) ? 2'b11 : 2'b00);
    end

`ifdef CLKDIV_GATE_EN
    step();                                    // 4
    gate = 2'b01;
    step();                                    // 5
    check("gate_div5", div_clk[0], 1'b0);
    check("gate_tick5", tick[0], 1'b0);
    step();                                    // 6
    check("gate_ch1_tick6", tick[1], 1'b1);
    step();                                    // 7
    check("gate_div7", div_clk[0], 1'b0);
    gate = 2'b00;
    step();                                    // 8
    check("gate_tick8", tick[0], 1'b0);
    step();                                    // 9
    check("gate_tick9", tick[0], 1'b0);
    step();                                    // 10
    check("gate_div10", div_clk[0], 1'b1);
    check("gate_tick10", tick[0], 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
